// File: rtl/sd_hc_pkg.sv
// Shared SD host-controller definitions: register offsets, access attributes
// and Clock Control register bit positions.
package sd_hc_pkg;

    localparam logic [11:0] CLK_CTRL   = 12'h02C;
    localparam logic [11:0] PRES_STATE = 12'h024;

    localparam logic [2:0] ATTR_RD = 3'h0;
    localparam logic [2:0] ATTR_RW = 3'h3;

    localparam int CLK_INT_EN_BIT     = 0;
    localparam int CLK_INT_STABLE_BIT = 1;
    localparam int CLK_SD_EN_BIT      = 2;

    // Clock Control write word: divider in [15:8], internal clock always enabled.
    function automatic logic [31:0] clk_ctrl_word(input logic [7:0] freq, input logic sd_en);
        logic [31:0] word;
        word                 = '0;
        word[15:8]           = freq;
        word[CLK_INT_EN_BIT] = 1'b1;
        word[CLK_SD_EN_BIT]  = sd_en;
        return word;
    endfunction

endpackage

// File: rtl/sd_wait_cntr.sv
// Fixed-length wait timer: a start strobe arms a 2-bit counter, and strb
// pulses for one cycle when the counter reaches 3.
module sd_wait_cntr (
    input  logic clk,
    input  logic reset,
    input  logic start_strb,
    output logic strb
);

    logic [1:0] cnt;
    logic       active;

    // A new start strobe restarts the count even if a wait is already running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= 2'd0;
            active <= 1'b0;
        end else if (start_strb) begin
            cnt    <= 2'd0;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == 2'd3) begin
                active <= 1'b0;
            end
            cnt <= cnt + 2'd1;
        end
    end

    assign strb = active && (cnt == 2'd3);

endmodule

// File: rtl/sd_clk_supply.sv
// SD clock supply sequencer: enables the internal clock, polls for Internal
// Clock Stable, then enables SDCLK. Define SD_CLK_SUP_TIMEOUT_EN to bound the
// polling with POLL_MAX and report sup_clk_err.
module sd_clk_supply
    import sd_hc_pkg::*;
#(
    parameter logic [7:0] POLL_MAX = 8'd255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sup_sd_clk_strb,
    input  logic [7:0]   freq_sel,
    output logic [11:0]  rd_reg_index,
    input  logic [127:0] rd_reg_input,
    output logic         wr_reg_strb,
    output logic [11:0]  wr_reg_index,
    output logic [31:0]  wr_reg_output,
    output logic [2:0]   reg_attr,
    output logic         sd_clk_on_suc,
    output logic         sup_clk_err,
    output logic         fin_sup_clk,
    output logic         sd_clk_sup_proc
);

    typedef enum logic [8:0] {
        IDLE      = 9'b0_0000_0001,
        WR_INT_EN = 9'b0_0000_0010,
        WR_INT_WT = 9'b0_0000_0100,
        RD_CLK    = 9'b0_0000_1000,
        RD_WT     = 9'b0_0001_0000,
        CHK       = 9'b0_0010_0000,
        WR_SD_EN  = 9'b0_0100_0000,
        WR_SD_WT  = 9'b0_1000_0000,
        FIN       = 9'b1_0000_0000
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] freq_q;
    logic       wait_strb;
    logic       wait_done_q;
    logic       rd_strb;
    logic       clk_stable;
    logic       poll_limit;
    logic       err_flag;

    assign rd_strb    = (state == RD_CLK);
    assign clk_stable = rd_reg_input[CLK_INT_STABLE_BIT];

    sd_wait_cntr u_wait (
        .clk        (clk),
        .reset      (reset),
        .start_strb (wr_reg_strb | rd_strb),
        .strb       (wait_strb)
    );

    // The wait states leave on the cycle after the timer pulse, hence the
    // registered copy of the pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            freq_q      <= 8'd0;
            wait_done_q <= 1'b0;
        end else begin
            state       <= next_state;
            wait_done_q <= wait_strb;
            if (state == IDLE && sup_sd_clk_strb) begin
                freq_q <= freq_sel;
            end
        end
    end

`ifdef SD_CLK_SUP_TIMEOUT_EN
    localparam logic [7:0] POLL_LIMIT = (POLL_MAX == 8'd0) ? 8'd1 : POLL_MAX;

    logic [7:0] poll_cnt;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            poll_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && sup_sd_clk_strb) begin
                poll_cnt <= 8'd0;
                err_q    <= 1'b0;
            end else if (state == RD_CLK && poll_cnt != 8'hFF) begin
                poll_cnt <= poll_cnt + 8'd1;
            end
            if (state == CHK && !clk_stable && poll_limit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign poll_limit = (poll_cnt >= POLL_LIMIT);
    assign err_flag   = err_q;
`else
    logic unused_poll_max;

    assign unused_poll_max = ^POLL_MAX;
    assign poll_limit      = 1'b0;
    assign err_flag        = 1'b0;
`endif

    logic unused_rd_bits;
    assign unused_rd_bits = ^{rd_reg_input[127:2], rd_reg_input[0]};

    // Register-port values are pure functions of state, so any reset or
    // return to IDLE drops them to zero immediately.
    always_comb begin
        next_state      = state;
        rd_reg_index    = 12'h000;
        wr_reg_strb     = 1'b0;
        wr_reg_index    = 12'h000;
        wr_reg_output   = 32'h0;
        reg_attr        = 3'h0;
        sd_clk_on_suc   = 1'b0;
        sup_clk_err     = 1'b0;
        fin_sup_clk     = 1'b0;
        sd_clk_sup_proc = (state != IDLE);

        case (state)
            IDLE: begin
                if (sup_sd_clk_strb) begin
                    next_state = WR_INT_EN;
                end
            end
            WR_INT_EN: begin
                wr_reg_strb   = 1'b1;
                wr_reg_index  = CLK_CTRL;
                wr_reg_output = clk_ctrl_word(freq_q, 1'b0);
                reg_attr      = ATTR_RW;
                next_state    = WR_INT_WT;
            end
            WR_INT_WT: begin
                wr_reg_index  = CLK_CTRL;
                wr_reg_output = clk_ctrl_word(freq_q, 1'b0);
                reg_attr      = ATTR_RW;
                if (wait_done_q) begin
                    next_state = RD_CLK;
                end
            end
            RD_CLK: begin
                rd_reg_index = CLK_CTRL;
                reg_attr     = ATTR_RD;
                next_state   = RD_WT;
            end
            RD_WT: begin
                rd_reg_index = CLK_CTRL;
                reg_attr     = ATTR_RD;
                if (wait_done_q) begin
                    next_state = CHK;
                end
            end
            CHK: begin
                if (clk_stable) begin
                    next_state = WR_SD_EN;
                end else if (poll_limit) begin
                    next_state = FIN;
                end else begin
                    next_state = RD_CLK;
                end
            end
            WR_SD_EN: begin
                wr_reg_strb   = 1'b1;
                wr_reg_index  = CLK_CTRL;
                wr_reg_output = clk_ctrl_word(freq_q, 1'b1);
                reg_attr      = ATTR_RW;
                next_state    = WR_SD_WT;
            end
            WR_SD_WT: begin
                wr_reg_index  = CLK_CTRL;
                wr_reg_output = clk_ctrl_word(freq_q, 1'b1);
                reg_attr      = ATTR_RW;
                if (wait_done_q) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                fin_sup_clk   = 1'b1;
                sd_clk_on_suc = !err_flag;
                sup_clk_err   = err_flag;
                next_state    = IDLE;
            end
            default: begin
                sd_clk_sup_proc = 1'b0;
                next_state      = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_clk_supply.sv
// Scoreboard bench for sd_clk_supply: stimulus queues expected writes and
// finish records, a negedge monitor checks them as the DUT produces them.
module tb_sd_clk_supply;

`ifdef SD_CLK_SUP_TIMEOUT_EN
    localparam logic [7:0] TB_POLL_MAX = 8'd3;
`else
    localparam logic [7:0] TB_POLL_MAX = 8'd255;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sup_sd_clk_strb = 1'b0;
    logic [7:0]   freq_sel = 8'h00;
    logic [11:0]  rd_reg_index;
    logic [127:0] rd_reg_input = '0;
    logic         wr_reg_strb;
    logic [11:0]  wr_reg_index;
    logic [31:0]  wr_reg_output;
    logic [2:0]   reg_attr;
    logic         sd_clk_on_suc;
    logic         sup_clk_err;
    logic         fin_sup_clk;
    logic         sd_clk_sup_proc;

    sd_clk_supply #(.POLL_MAX(TB_POLL_MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .sup_sd_clk_strb (sup_sd_clk_strb),
        .freq_sel        (freq_sel),
        .rd_reg_index    (rd_reg_index),
        .rd_reg_input    (rd_reg_input),
        .wr_reg_strb     (wr_reg_strb),
        .wr_reg_index    (wr_reg_index),
        .wr_reg_output   (wr_reg_output),
        .reg_attr        (reg_attr),
        .sd_clk_on_suc   (sd_clk_on_suc),
        .sup_clk_err     (sup_clk_err),
        .fin_sup_clk     (fin_sup_clk),
        .sd_clk_sup_proc (sd_clk_sup_proc)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          is_fin;
        logic [11:0] idx;
        logic [31:0] data;
        logic [2:0]  attr;
        logic [2:0]  flags;
        int          lat;
        int          reads;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stable_after = 1;
    int          cyc = 0;
    int          start_cyc = 0;
    int          reads = 0;
    int          fins_seen = 0;
    int          fin_target = 0;
    logic        prev_proc = 1'b0;
    logic [11:0] prev_rd_idx = 12'h000;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Register-file responder and scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            prev_proc   = 1'b0;
            prev_rd_idx = 12'h000;
            reads       = 0;
        end else begin
            if (sd_clk_sup_proc && !prev_proc) begin
                start_cyc = cyc - 1;
                reads     = 0;
            end
            if (rd_reg_index == 12'h02C && prev_rd_idx != 12'h02C) begin
                reads++;
            end
            rd_reg_input      = '0;
            rd_reg_input[0]   = 1'b1;
            rd_reg_input[1]   = (reads >= stable_after);
            rd_reg_input[127] = 1'b1;
            if (wr_reg_strb) begin
                if (exp_q.size() == 0 || exp_q[0].is_fin) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got idx %0h data %0h, none expected", wr_reg_index, wr_reg_output);
                end else begin
                    e = exp_q.pop_front();
                    check_output("wr_index", 64'(wr_reg_index), 64'(e.idx));
                    check_output("wr_data", 64'(wr_reg_output), 64'(e.data));
                    check_output("wr_attr", 64'(reg_attr), 64'(e.attr));
                end
            end
            if (fin_sup_clk || sd_clk_on_suc || sup_clk_err) begin
                fins_seen++;
                if (exp_q.size() == 0 || !exp_q[0].is_fin) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_finish: got fin/suc/err %b%b%b, none expected", fin_sup_clk, sd_clk_on_suc, sup_clk_err);
                end else begin
                    e = exp_q.pop_front();
                    check_output("fin_flags", 64'({fin_sup_clk, sd_clk_on_suc, sup_clk_err}), 64'(e.flags));
                    check_output("latency", 64'(cyc - start_cyc), 64'(e.lat));
                    check_output("read_count", 64'(reads), 64'(e.reads));
                end
            end
            prev_proc   = sd_clk_sup_proc;
            prev_rd_idx = rd_reg_index;
        end
    end

    task automatic apply_stimulus(input logic [7:0] f, input int n_reads, input bit ok, input bit with_fin);
        exp_t e;
        e.is_fin = 1'b0;
        e.idx    = 12'h02C;
        e.data   = {16'h0000, f, 8'h01};
        e.attr   = 3'h3;
        e.flags  = 3'b000;
        e.lat    = 0;
        e.reads  = 0;
        exp_q.push_back(e);
        if (ok) begin
            e.data = {16'h0000, f, 8'h05};
            exp_q.push_back(e);
        end
        if (with_fin) begin
            e.is_fin = 1'b1;
            e.flags  = ok ? 3'b110 : 3'b101;
            e.lat    = ok ? (20 + 7 * (n_reads - 1)) : (7 + 7 * n_reads);
            e.reads  = n_reads;
            exp_q.push_back(e);
            fin_target++;
        end
        @(negedge clk);
        freq_sel        = f;
        sup_sd_clk_strb = 1'b1;
        @(negedge clk);
        sup_sd_clk_strb = 1'b0;
        freq_sel        = ~f;
    endtask

    task automatic check_idle(input string name);
        check_output(name, {rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr,
                            sd_clk_on_suc, sup_clk_err, fin_sup_clk, sd_clk_sup_proc}, 64'h0);
    endtask

    task automatic wait_fin(input string name, input int budget);
        int n;
        n = 0;
        while (fins_seen < fin_target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (fins_seen < fin_target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d finishes expected %0d", name, fins_seen, fin_target);
        end
        repeat (2) @(negedge clk);
        check_idle({name, "_idle"});
    endtask

    initial begin
        int n;
        int fins_before;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] stable on first read, freq 80");
        stable_after = 1;
        apply_stimulus(8'h80, 1, 1'b1, 1'b1);
        wait_fin("first_read", 200);

`ifndef SD_CLK_SUP_TIMEOUT_EN
        $display("[TB] stable on fourth read");
        stable_after = 4;
        apply_stimulus(8'h21, 4, 1'b1, 1'b1);
        wait_fin("fourth_read", 400);
`else
        $display("[TB] never stable, poll limit 3");
        stable_after = 1000;
        apply_stimulus(8'h33, 3, 1'b0, 1'b1);
        wait_fin("poll_timeout", 400);
`endif

        $display("[TB] second request during read wait is ignored");
        stable_after = 1;
        apply_stimulus(8'h3C, 1, 1'b1, 1'b1);
        n = 0;
        while (rd_reg_index != 12'h02C && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("reached_read", 64'(rd_reg_index), 64'h02C);
        repeat (2) @(negedge clk);
        freq_sel        = 8'hAA;
        sup_sd_clk_strb = 1'b1;
        @(negedge clk);
        sup_sd_clk_strb = 1'b0;
        wait_fin("ignored_strobe", 200);

        $display("[TB] reset during SD-enable wait");
        apply_stimulus(8'h42, 1, 1'b1, 1'b0);
        n = 0;
        while (!(wr_reg_strb && wr_reg_output[7:0] == 8'h05) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("reached_sd_en", 64'(wr_reg_output), 64'h4205);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("mid_reset_outputs");
        reset       = 1'b1;
        fins_before = fins_seen;
        repeat (30) @(negedge clk);
        check_output("no_fin_after_reset", 64'(fins_seen), 64'(fins_before));
        check_idle("post_reset_idle");
        apply_stimulus(8'h5A, 1, 1'b1, 1'b1);
        wait_fin("after_reset", 200);

`ifndef SD_CLK_SUP_TIMEOUT_EN
        $display("[TB] stable after 300 reads, no timeout");
        stable_after = 300;
        apply_stimulus(8'h01, 300, 1'b1, 1'b1);
        wait_fin("long_poll", 5000);
`endif

        repeat (5) @(negedge clk);
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
